conv_job_sequencer: RTL and testbench
=====================================

// Module: conv_job_sequencer
// PURPOSE
//  Queues convolution jobs (sizeX, sizeY, tag) from the host and runs them one at a time on the conv processor core.
//  Drives the core's level-sensitive init, watches done/busy, and enforces a watchdog timeout.
//  Counts completed jobs and raises a one-cycle irq per completed or failed job.
//  Sits between the host register bank and the conv processor FSM/datapath.
// PARAMETERS
//  SIZE_W   5   width of sizeX/sizeY job fields
//  TAG_W    4   width of host-supplied job tag
//  DEPTH    4   job FIFO entries; power of 2, >=2
//  TMO_W    16  watchdog counter width; timeout at 2^TMO_W-1 cycles in WAIT_DONE
//  CNT_W    8   completed-job counter width
// PORTS
//  clk            in   1        clock, rising edge
//  rstn           in   1        asynchronous reset, active low
//  enable_in      in   1        1 = sequencer may launch queued jobs
//  job_valid_in   in   1        host offers a job this cycle
//  job_ready_out  out  1        FIFO can accept a job (= !full)
//  job_sizeX_in   in   SIZE_W   job X length
//  job_sizeY_in   in   SIZE_W   job Y length
//  job_tag_in     in   TAG_W    job tag
//  clr_err_in     in   1        clears sticky error, leaves ERROR
//  done_in        in   1        core done (1-cycle pulse)
//  busy_in        in   1        core busy
//  init_out       out  1        core start, level; held until done seen
//  cfg_sizeX_out  out  SIZE_W   sizeX of running job
//  cfg_sizeY_out  out  SIZE_W   sizeY of running job
//  cur_tag_out    out  TAG_W    tag of running/last job
//  fifo_count_out out  log2(DEPTH)+1  entries queued
//  jobs_done_out  out  CNT_W    completed jobs, wraps
//  tmo_err_out    out  1        sticky watchdog error
//  irq_out        out  1        1-cycle pulse on job complete or timeout
//  idle_out       out  1        1 only in IDLE
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, all outputs 0 except job_ready_out=1, idle_out=1.
//  FIFO: push when job_valid_in & job_ready_out; pop only in LOAD. Push+pop same cycle -> count unchanged.
//   job_ready_out is derived from the current count; when full, a push is refused even in the LOAD cycle. Pointers wrap mod DEPTH.
//  FSM (registered state; Moore outputs):
//   IDLE: enable_in & count!=0 -> LOAD; else stay.
//   LOAD: pop head into cfg_size*/cur_tag registers; clear timer -> START.
//   START: init_out=1 -> WAIT_DONE.
//   WAIT_DONE: init_out=1, timer+1 per cycle.
//    done_in -> RELEASE (done has priority over timeout in the same cycle).
//    timer==2^TMO_W-1 -> ERROR.
//   RELEASE: init_out=0 for at least 2 cycles and until busy_in=0 -> REPORT.
//   REPORT: irq_out=1, jobs_done+1 (wraps) -> IDLE.
//   ERROR: init_out=0; tmo_err_out set on entry with a 1-cycle irq_out; hold until clr_err_in -> IDLE, clearing tmo_err_out. FIFO is preserved.
//  done_in outside WAIT_DONE is ignored. Deasserting enable_in mid-job does not abort the job; it only blocks the next launch.
//  cfg_size*/cur_tag remain stable from LOAD until the next LOAD.
//  Latency: FIFO non-empty in IDLE -> init_out high 2 cycles later (LOAD, START).
//  Zero-size jobs are legal; the core returns done with no busy phase.
// TESTING
//  1 push (X=3,Y=2,tag=5), enable=1 -> init high 2 cycles later; model done after 20 cycles -> init low, irq 1 pulse, jobs_done=1, cur_tag=5.
//  2 push 4 jobs back-to-back with enable=0 -> count=4, ready=0; 5th valid refused; enable=1 -> jobs run in FIFO order, irq x4.
//  3 core never sends done, TMO_W=4 -> ERROR after 15 WAIT_DONE cycles, init=0, tmo_err=1, irq pulse; clr_err -> IDLE, next job launches.
//  4 done and timeout in same cycle -> REPORT path, tmo_err stays 0.
//  5 rstn low during WAIT_DONE -> init=0, FIFO empty, jobs_done=0, idle=1 immediately (async).
//  6 full FIFO, push offered during LOAD -> refused; count=DEPTH-1 afterward.

Source files
------------

// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer
// Queues convolution jobs from the host in a small FIFO and launches them one
// at a time on the conv processor core. It holds the core's level-sensitive init
// until done is seen, guards each run with a watchdog, counts completed jobs and
// pulses irq once per completed or timed-out job.
module conv_job_sequencer #(
  parameter int SIZE_W = 5,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4,
  parameter int TMO_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable_in,
  input  logic                       job_valid_in,
  output logic                       job_ready_out,
  input  logic [SIZE_W-1:0]          job_sizeX_in,
  input  logic [SIZE_W-1:0]          job_sizeY_in,
  input  logic [TAG_W-1:0]           job_tag_in,
  input  logic                       clr_err_in,
  input  logic                       done_in,
  input  logic                       busy_in,
  output logic                       init_out,
  output logic [SIZE_W-1:0]          cfg_sizeX_out,
  output logic [SIZE_W-1:0]          cfg_sizeY_out,
  output logic [TAG_W-1:0]           cur_tag_out,
  output logic [$clog2(DEPTH):0]     fifo_count_out,
  output logic [CNT_W-1:0]           jobs_done_out,
  output logic                       tmo_err_out,
  output logic                       irq_out,
  output logic                       idle_out
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam int JOB_W  = 2 * SIZE_W + TAG_W;
  localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(DEPTH);
  localparam logic [TMO_W-1:0]  TMO_MAX  = {TMO_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RELEASE   = 3'd4,
    S_REPORT    = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   timer_q, timer_d;
  logic               rel_q, rel_d;

  logic [JOB_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_FW-1:0]  count_q, count_d;

  logic [SIZE_W-1:0]  cfg_x_q, cfg_y_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CNT_W-1:0]   jobs_done_q;
  logic               init_q, irq_q, idle_q, tmo_err_q;

  logic               ready_s, push_s, pop_s;
  logic [TMO_W-1:0]   timer_inc_s;

  // Ready is a pure function of the registered count, so a full FIFO refuses
  // a push even in the cycle that pops it.
  assign ready_s     = (count_q != FULL_CNT);
  assign push_s      = job_valid_in & ready_s;
  assign pop_s       = (state_q == S_LOAD);
  assign timer_inc_s = timer_q + {{(TMO_W-1){1'b0}}, 1'b1};

  // Occupancy bookkeeping: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CNT_FW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNT_FW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_FW{1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= {job_sizeX_in, job_sizeY_in, job_tag_in};
  end

  // Next-state logic with watchdog timer and the minimum-two-cycle release hold.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rel_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_in && (count_q != {CNT_FW{1'b0}})) state_d = S_LOAD;
        else                                          state_d = S_IDLE;
      end
      S_LOAD: begin
        timer_d = {TMO_W{1'b0}};
        state_d = S_START;
      end
      S_START: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        timer_d = timer_inc_s;
        // done wins over a timeout landing in the same cycle
        if (done_in)                     state_d = S_RELEASE;
        else if (timer_inc_s == TMO_MAX) state_d = S_ERROR;
        else                             state_d = S_WAIT_DONE;
      end
      S_RELEASE: begin
        rel_d = 1'b1;
        if (rel_q && !busy_in) state_d = S_REPORT;
        else                   state_d = S_RELEASE;
      end
      S_REPORT: state_d = S_IDLE;
      S_ERROR: begin
        if (clr_err_in) state_d = S_IDLE;
        else            state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, timer and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      timer_q     <= {TMO_W{1'b0}};
      rel_q       <= 1'b0;
      init_q      <= 1'b0;
      irq_q       <= 1'b0;
      idle_q      <= 1'b1;
      tmo_err_q   <= 1'b0;
      jobs_done_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rel_q     <= rel_d;
      init_q    <= (state_d == S_START) || (state_d == S_WAIT_DONE);
      irq_q     <= (state_d == S_REPORT) ||
                   ((state_d == S_ERROR) && (state_q != S_ERROR));
      idle_q    <= (state_d == S_IDLE);
      tmo_err_q <= (state_d == S_ERROR);
      if (state_q == S_REPORT) jobs_done_q <= jobs_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Running-job configuration, captured from the FIFO head in LOAD only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_x_q <= {SIZE_W{1'b0}};
      cfg_y_q <= {SIZE_W{1'b0}};
      tag_q   <= {TAG_W{1'b0}};
    end else if (pop_s) begin
      {cfg_x_q, cfg_y_q, tag_q} <= mem_q[rd_ptr_q];
    end
  end

  assign job_ready_out  = ready_s;
  assign init_out       = init_q;
  assign cfg_sizeX_out  = cfg_x_q;
  assign cfg_sizeY_out  = cfg_y_q;
  assign cur_tag_out    = tag_q;
  assign fifo_count_out = count_q;
  assign jobs_done_out  = jobs_done_q;
  assign tmo_err_out    = tmo_err_q;
  assign irq_out        = irq_q;
  assign idle_out       = idle_q;

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Testbench for conv_job_sequencer: directed scenario sequence with randomized
// job contents and core timing, checked against a queue-based job model.
module tb_conv_job_sequencer;

  localparam int SIZE_W  = 5;
  localparam int TAG_W   = 4;
  localparam int DEPTH   = 4;
  localparam int TMO_W   = 6;
  localparam int CNT_W   = 8;
  localparam int TMO_MAX = (1 << TMO_W) - 1;

  logic clk = 1'b0;
  logic rstn, enable_in, job_valid_in, job_ready_out, clr_err_in, done_in, busy_in;
  logic [SIZE_W-1:0] job_sizeX_in, job_sizeY_in, cfg_sizeX_out, cfg_sizeY_out;
  logic [TAG_W-1:0]  job_tag_in, cur_tag_out;
  logic [$clog2(DEPTH):0] fifo_count_out;
  logic [CNT_W-1:0]  jobs_done_out;
  logic init_out, tmo_err_out, irq_out, idle_out;

  conv_job_sequencer #(.SIZE_W(SIZE_W), .TAG_W(TAG_W), .DEPTH(DEPTH),
                       .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .enable_in(enable_in),
    .job_valid_in(job_valid_in), .job_ready_out(job_ready_out),
    .job_sizeX_in(job_sizeX_in), .job_sizeY_in(job_sizeY_in), .job_tag_in(job_tag_in),
    .clr_err_in(clr_err_in), .done_in(done_in), .busy_in(busy_in),
    .init_out(init_out), .cfg_sizeX_out(cfg_sizeX_out), .cfg_sizeY_out(cfg_sizeY_out),
    .cur_tag_out(cur_tag_out), .fifo_count_out(fifo_count_out),
    .jobs_done_out(jobs_done_out), .tmo_err_out(tmo_err_out),
    .irq_out(irq_out), .idle_out(idle_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int t;
  } job_t;

  job_t model_q[$];
  job_t cur_job;
  int   model_done;
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Offer one job for a cycle; the model decides acceptance from its own occupancy.
  task automatic push_job(input int x, input int y, input int t);
    bit acc;
    job_t j;
    acc = (model_q.size() < DEPTH);
    job_valid_in = 1'b1;
    job_sizeX_in = SIZE_W'(x);
    job_sizeY_in = SIZE_W'(y);
    job_tag_in   = TAG_W'(t);
    chk("push_ready", job_ready_out, acc);
    step();
    job_valid_in = 1'b0;
    if (acc) begin
      j.x = x; j.y = y; j.t = t;
      model_q.push_back(j);
    end
    chk("push_count", fifo_count_out, model_q.size());
  endtask

  task automatic push_rand();
    push_job($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 15));
  endtask

  // From an IDLE cycle with work queued: init must rise two cycles later.
  task automatic launch();
    enable_in = 1'b1;
    step();
    chk("load_init", init_out, 0);
    chk("load_idle", idle_out, 0);
    step();
    chk("start_init", init_out, 1);
    cur_job = model_q.pop_front();
    chk("cfg_x", cfg_sizeX_out, cur_job.x);
    chk("cfg_y", cfg_sizeY_out, cur_job.y);
    chk("cfg_tag", cur_tag_out, cur_job.t);
    chk("launch_count", fifo_count_out, model_q.size());
  endtask

  // Core answers done in wait cycle w, then stays busy for b more cycles.
  task automatic finish(input int w, input int b);
    int cyc;
    int exp_delay;
    for (int i = 1; i <= w; i++) begin
      busy_in = (b > 0);
      step();
      chk("wait_init", init_out, 1);
      if (i == w) done_in = 1'b1;
    end
    step();
    done_in = 1'b0;
    chk("release_init", init_out, 0);
    cyc = 1;
    busy_in = (b >= 1);
    while (irq_out !== 1'b1 && cyc < 30) begin
      step();
      cyc++;
      busy_in = (cyc <= b);
    end
    exp_delay = (b + 2 > 3) ? b + 2 : 3;
    chk("irq_delay", cyc, exp_delay);
    chk("report_tmo", tmo_err_out, 0);
    busy_in = 1'b0;
    step();
    model_done = (model_done + 1) % (1 << CNT_W);
    chk("irq_pulse", irq_out, 0);
    chk("after_idle", idle_out, 1);
    chk("jobs_done", jobs_done_out, model_done);
    chk("tag_hold", cur_tag_out, cur_job.t);
  endtask

  task automatic finish_rand();
    finish($urandom_range(1, 40), $urandom_range(0, 4));
  endtask

  // Core never answers: watchdog must fire after TMO_MAX wait cycles.
  task automatic timeout_and_clear();
    for (int i = 1; i <= TMO_MAX; i++) begin
      busy_in = 1'b1;
      step();
      chk("tmo_wait_init", init_out, 1);
    end
    step();
    busy_in = 1'b0;
    chk("err_init", init_out, 0);
    chk("err_irq", irq_out, 1);
    chk("err_tmo", tmo_err_out, 1);
    chk("err_idle", idle_out, 0);
    step();
    chk("err_irq_pulse", irq_out, 0);
    repeat (3) step();
    chk("err_hold_tmo", tmo_err_out, 1);
    chk("err_hold_idle", idle_out, 0);
    chk("err_fifo_kept", fifo_count_out, model_q.size());
    clr_err_in = 1'b1;
    step();
    clr_err_in = 1'b0;
    chk("clr_tmo", tmo_err_out, 0);
    chk("clr_idle", idle_out, 1);
    chk("clr_jobs_done", jobs_done_out, model_done);
  endtask

  initial begin
    checks = 0; errors = 0; model_done = 0;
    rstn = 1'b0; enable_in = 1'b0; job_valid_in = 1'b0; clr_err_in = 1'b0;
    done_in = 1'b0; busy_in = 1'b0;
    job_sizeX_in = '0; job_sizeY_in = '0; job_tag_in = '0;
    repeat (2) step();
    chk("rst_ready", job_ready_out, 1);
    chk("rst_idle", idle_out, 1);
    chk("rst_init", init_out, 0);
    chk("rst_irq", irq_out, 0);
    chk("rst_tmo", tmo_err_out, 0);
    chk("rst_count", fifo_count_out, 0);
    chk("rst_jobs", jobs_done_out, 0);
    chk("rst_tag", cur_tag_out, 0);
    rstn = 1'b1;
    step();

    // single job, done after 20 cycles
    push_job(3, 2, 5);
    launch();
    finish(20, 3);
    chk("t1_tag", cur_tag_out, 5);

    // stray done in IDLE is ignored
    enable_in = 1'b0;
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    step();
    chk("stray_idle", idle_out, 1);
    chk("stray_init", init_out, 0);
    chk("stray_jobs", jobs_done_out, model_done);

    // fill FIFO, 5th offer refused, then drain in order
    repeat (5) push_rand();
    chk("full_ready", job_ready_out, 0);
    repeat (DEPTH) begin
      launch();
      finish_rand();
    end
    step();
    chk("drained_idle", idle_out, 1);
    chk("drained_count", fifo_count_out, 0);

    // watchdog, clear, then the queued job launches
    enable_in = 1'b0;
    push_rand();
    push_rand();
    launch();
    timeout_and_clear();
    launch();
    finish(5, 0);

    // done on the very cycle the watchdog would expire
    push_rand();
    launch();
    finish(TMO_MAX, 0);

    // dropping enable mid-job only blocks the next launch
    enable_in = 1'b0;
    push_rand();
    push_rand();
    launch();
    enable_in = 1'b0;
    finish_rand();
    repeat (3) step();
    chk("blocked_idle", idle_out, 1);
    chk("blocked_count", fifo_count_out, 1);
    launch();
    finish_rand();

    // full FIFO, push offered during LOAD is refused
    enable_in = 1'b0;
    repeat (DEPTH) push_rand();
    enable_in = 1'b1;
    step();
    chk("t6_load_ready", job_ready_out, 0);
    chk("t6_load_count", fifo_count_out, DEPTH);
    job_valid_in = 1'b1;
    job_sizeX_in = 5'd7; job_sizeY_in = 5'd7; job_tag_in = 4'd9;
    step();
    job_valid_in = 1'b0;
    cur_job = model_q.pop_front();
    chk("t6_count", fifo_count_out, DEPTH - 1);
    chk("t6_init", init_out, 1);
    chk("t6_tag", cur_tag_out, cur_job.t);
    finish_rand();
    repeat (DEPTH - 1) begin
      launch();
      finish_rand();
    end

    // asynchronous reset in the middle of WAIT_DONE
    enable_in = 1'b0;
    push_rand();
    push_rand();
    launch();
    busy_in = 1'b1;
    repeat (5) step();
    #2 rstn = 1'b0;
    #1;
    chk("arst_init", init_out, 0);
    chk("arst_idle", idle_out, 1);
    chk("arst_count", fifo_count_out, 0);
    chk("arst_jobs", jobs_done_out, 0);
    chk("arst_ready", job_ready_out, 1);
    model_q.delete();
    model_done = 0;
    busy_in = 1'b0;
    enable_in = 1'b0;
    step();
    rstn = 1'b1;
    step();

    // post-reset job still works
    push_rand();
    launch();
    finish_rand();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
